// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the MEM-stage data memory initiator.
//   - access size encodings (SZ_*), FSM state enum, all-lanes byte enable
//   - helpers for alignment checking, store byte enables and store lane
//     replication
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // True when the access cannot be issued as a single aligned word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lane[0];
      SZ_WORD: mis = (lane != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Byte enables for an aligned store; lane 0 is bits 7:0 (little-endian).
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = BE_ALL;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across all lanes so the memory
  // picks the right bytes purely from the byte enables.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{data[7:0]}};
      SZ_HALF: r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational lane extraction and sign/zero extension of a
// 32-bit memory word.
//   din      in  32  word as returned by memory (lane 0 = bits 7:0)
//   lane     in  2   byte address bits [1:0] of the access
//   size     in  2   SZ_BYTE / SZ_HALF / SZ_WORD (SZ_ILL yields 0)
//   sign_ext in  1   sign-extend byte/half results, else zero-extend
//   dout     out 32  right-justified, extended result
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] din,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] dout
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = din[8*gi +: 8];
  end

  assign byte_val = lanes[lane];
  assign half_val = lane[1] ? din[31:16] : din[15:0];

  always_comb begin
    dout = '0;
    case (size)
      SZ_BYTE: dout = {{24{sign_ext & byte_val[7]}}, byte_val};
      SZ_HALF: dout = {{16{sign_ext & half_val[15]}}, half_val};
      SZ_WORD: dout = din;
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator between the EX/MEM register and a
// multi-cycle word-addressed data memory (req/ack handshake).
//   clk, rst            clock; synchronous active-high reset
//   ex_valid/memread/memwrite/size/signed/addr/wdata
//                       request from EX/MEM, held by the pipeline while stalled
//   stall               holds IF..EX/MEM while an access is in flight
//   done, rdata         one-cycle completion pulse with aligned load data
//   err_align           with done: misaligned access or illegal size
//   err_timeout         with done: memory did not ack within TIMEOUT cycles
//   mem_req/we/addr/be/wdata
//                       registered request to memory, stable until ack
//   mem_ack, mem_rdata  completion and read data from memory
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err_align,
  output logic              err_timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               req_reg, req_next;
  logic               we_reg, we_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [3:0]         be_reg, be_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic [31:0]        rdata_reg, rdata_next;
  logic               err_align_reg, err_align_next;
  logic               err_timeout_reg, err_timeout_next;
  // Load shape captured at accept so extraction does not depend on ex_* later.
  logic [1:0]         size_reg, size_next;
  logic [1:0]         lane_reg, lane_next;
  logic               sign_reg, sign_next;

  logic               access;
  logic               misaligned;
  logic [31:0]        load_data;

  // Only the word-address bits reach memory; higher address bits are ignored.
  logic               unused_addr;
  assign unused_addr = ^ex_addr[31:ADDR_W+2];

  assign access     = ex_valid & (ex_memread | ex_memwrite);
  assign misaligned = is_misaligned(ex_size, ex_addr[1:0]);

  load_align u_load_align (
    .din      (mem_rdata),
    .lane     (lane_reg),
    .size     (size_reg),
    .sign_ext (sign_reg),
    .dout     (load_data)
  );

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    req_next         = req_reg;
    we_next          = we_reg;
    addr_next        = addr_reg;
    be_next          = be_reg;
    wdata_next       = wdata_reg;
    rdata_next       = rdata_reg;
    err_align_next   = err_align_reg;
    err_timeout_next = err_timeout_reg;
    size_next        = size_reg;
    lane_next        = lane_reg;
    sign_next        = sign_reg;
    stall            = 1'b0;
    done             = 1'b0;

    case (state_reg)
      IDLE: begin
        stall = access;
        if (access) begin
          rdata_next = '0;
          if (misaligned) begin
            err_align_next = 1'b1;
            state_next     = DONE;
          end else begin
            // Write wins when both memread and memwrite are set.
            req_next   = 1'b1;
            we_next    = ex_memwrite;
            addr_next  = ex_addr[ADDR_W+1:2];
            be_next    = ex_memwrite ? store_be(ex_size, ex_addr[1:0]) : BE_ALL;
            wdata_next = ex_memwrite ? replicate(ex_size, ex_wdata) : '0;
            size_next  = ex_size;
            lane_next  = ex_addr[1:0];
            sign_next  = ex_signed;
            cnt_next   = '0;
            state_next = BUSY;
          end
        end
      end

      BUSY: begin
        stall    = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        // An ack in the last allowed cycle still completes normally.
        if (mem_ack) begin
          req_next   = 1'b0;
          rdata_next = we_reg ? '0 : load_data;
          state_next = DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          req_next         = 1'b0;
          err_timeout_next = 1'b1;
          rdata_next       = '0;
          state_next       = DONE;
        end
      end

      DONE: begin
        // ex_* are deliberately not looked at here: the pipeline advances at
        // the end of this cycle, so the same instruction is never re-accepted.
        done             = 1'b1;
        rdata_next       = '0;
        err_align_next   = 1'b0;
        err_timeout_next = 1'b0;
        state_next       = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      req_reg         <= 1'b0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      be_reg          <= '0;
      wdata_reg       <= '0;
      rdata_reg       <= '0;
      err_align_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
      size_reg        <= SZ_BYTE;
      lane_reg        <= '0;
      sign_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      req_reg         <= req_next;
      we_reg          <= we_next;
      addr_reg        <= addr_next;
      be_reg          <= be_next;
      wdata_reg       <= wdata_next;
      rdata_reg       <= rdata_next;
      err_align_reg   <= err_align_next;
      err_timeout_reg <= err_timeout_next;
      size_reg        <= size_next;
      lane_reg        <= lane_next;
      sign_reg        <= sign_next;
    end
  end

  assign mem_req     = req_reg;
  assign mem_we      = we_reg;
  assign mem_addr    = addr_reg;
  assign mem_be      = be_reg;
  assign mem_wdata   = wdata_reg;
  assign rdata       = rdata_reg;
  assign err_align   = err_align_reg;
  assign err_timeout = err_timeout_reg;

endmodule
